// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable first-word-fall-through read mode.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];
    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    // Next-state pointers, occupancy and flags, all derived from the next count
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_THRESH));
        ae_d    = (count_d <= CW'(AE_THRESH));
    end

    // Control state register; reset discards all stored words logically
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly from storage; forced to zero while empty
            // so the output never exposes unwritten memory
            assign data_out   = empty_q ? '0 : mem_q[rd_idx];
            assign data_valid = !empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_q;
            logic                  data_valid_q;

            // Registered read port: load on accepted pop, hold otherwise
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_out_q   <= '0;
                    data_valid_q <= 1'b0;
                end else begin
                    data_valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_out_q <= mem_q[rd_idx];
                    end
                end
            end

            assign data_out   = data_out_q;
            assign data_valid = data_valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
